// File: rtl/alu_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq_if
// Purpose : groups the command and result valid/ready channels of the ALU
//           issue stage into one bundle.
// Signals :
//   command channel : i_b_cmd_valid, o_b_cmd_ready, i_ul_a, i_ul_b, i_u3_sel
//   result channel  : o_b_res_valid, i_b_res_ready, o_ul_r, o_bi_zflag,
//                     o_u3_res_sel
//   status          : o_u8_done_cnt (completed result handshakes, wraps)
// Modports:
//   slave  - the issue stage (accepts commands, produces results)
//   master - the producer/consumer side (drives commands, takes results)
// ---------------------------------------------------------------------------
interface alu_cmd_seq_if #(
    parameter int W = 32
) ();
    logic         i_b_cmd_valid;
    logic         o_b_cmd_ready;
    logic [W-1:0] i_ul_a;
    logic [W-1:0] i_ul_b;
    logic [2:0]   i_u3_sel;
    logic         o_b_res_valid;
    logic         i_b_res_ready;
    logic [W-1:0] o_ul_r;
    logic         o_bi_zflag;
    logic [2:0]   o_u3_res_sel;
    logic [7:0]   o_u8_done_cnt;

    modport slave (
        input  i_b_cmd_valid, i_ul_a, i_ul_b, i_u3_sel, i_b_res_ready,
        output o_b_cmd_ready, o_b_res_valid, o_ul_r, o_bi_zflag,
               o_u3_res_sel, o_u8_done_cnt
    );

    modport master (
        output i_b_cmd_valid, i_ul_a, i_ul_b, i_u3_sel, i_b_res_ready,
        input  o_b_cmd_ready, o_b_res_valid, o_ul_r, o_bi_zflag,
               o_u3_res_sel, o_u8_done_cnt
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq
// Purpose : issue stage in front of a clocked ALU. Commands (a, b, sel) are
//           buffered in a DEPTH-entry FIFO, issued one at a time on held
//           operand/selector outputs, the result is captured after the ALU's
//           register latency and then offered downstream until accepted.
// Ports   :
//   clk, rst_n        - clock, synchronous active-low reset
//   bus (slave)       - command and result valid/ready channels + done count
//   o_ul_alu_a/b      - operands driven to the ALU (held between issues)
//   o_u3_alu_sel      - operation select driven to the ALU
//   i_ul_alu_r        - ALU result
//   i_b_alu_zflag     - ALU zero flag
// ---------------------------------------------------------------------------
module alu_cmd_seq #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_cmd_seq_if.slave  bus,
    output logic [W-1:0]  o_ul_alu_a,
    output logic [W-1:0]  o_ul_alu_b,
    output logic [2:0]    o_u3_alu_sel,
    input  logic [W-1:0]  i_ul_alu_r,
    input  logic          i_b_alu_zflag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(ALU_LAT + 2);

    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_EMPTY = {(PW + 1){1'b0}};
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    // One extra edge beyond the ALU latency: the pop edge only loads the
    // operand registers, the ALU samples them on the following edge.
    localparam logic [CW-1:0] WAIT_LOAD = CW'(ALU_LAT + 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;

    logic [W-1:0]  fifo_a_r   [DEPTH];
    logic [W-1:0]  fifo_b_r   [DEPTH];
    logic [2:0]    fifo_sel_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [PW:0]   count_next_s;
    logic          cmd_ready_r;

    logic          push_s;
    logic          pop_s;
    logic          capture_s;
    logic          handshake_s;
    logic          fifo_empty_s;

    logic [CW-1:0] wait_cnt_r;
    logic [W-1:0]  alu_a_r;
    logic [W-1:0]  alu_b_r;
    logic [2:0]    alu_sel_r;

    logic          res_valid_r;
    logic [W-1:0]  res_r;
    logic          zflag_r;
    logic [2:0]    res_sel_r;
    logic [7:0]    done_cnt_r;

    // Outputs are straight copies of registers.
    assign bus.o_b_cmd_ready = cmd_ready_r;
    assign bus.o_b_res_valid = res_valid_r;
    assign bus.o_ul_r        = res_r;
    assign bus.o_bi_zflag    = zflag_r;
    assign bus.o_u3_res_sel  = res_sel_r;
    assign bus.o_u8_done_cnt = done_cnt_r;
    assign o_ul_alu_a        = alu_a_r;
    assign o_ul_alu_b        = alu_b_r;
    assign o_u3_alu_sel      = alu_sel_r;

    // Ready is registered, so a push can never race a full FIFO.
    assign push_s       = bus.i_b_cmd_valid & cmd_ready_r;
    assign fifo_empty_s = (count_r == CNT_EMPTY);

    // Next-state and control strobes of the issue FSM.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        handshake_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_ONE) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (bus.i_b_res_ready) begin
                    handshake_s = 1'b1;
                    // Issue the next command on the handshake edge so a
                    // steady stream costs ALU_LAT+2 cycles per result.
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this edge's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_a_r[wr_ptr_r]   <= bus.i_ul_a;
            fifo_b_r[wr_ptr_r]   <= bus.i_ul_b;
            fifo_sel_r[wr_ptr_r] <= bus.i_u3_sel;
        end
    end

    // FIFO pointers, occupancy and ready flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= CNT_EMPTY;
            cmd_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Issue registers driving the ALU plus the latency counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_r    <= {W{1'b0}};
            alu_b_r    <= {W{1'b0}};
            alu_sel_r  <= 3'b000;
            wait_cnt_r <= {CW{1'b0}};
        end else if (pop_s) begin
            alu_a_r    <= fifo_a_r[rd_ptr_r];
            alu_b_r    <= fifo_b_r[rd_ptr_r];
            alu_sel_r  <= fifo_sel_r[rd_ptr_r];
            wait_cnt_r <= WAIT_LOAD;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
        end
    end

    // Result capture, downstream valid and completed-handshake counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_r       <= {W{1'b0}};
            zflag_r     <= 1'b0;
            res_sel_r   <= 3'b000;
            done_cnt_r  <= 8'd0;
        end else begin
            if (capture_s) begin
                res_valid_r <= 1'b1;
                res_r       <= i_ul_alu_r;
                zflag_r     <= i_b_alu_zflag;
                res_sel_r   <= alu_sel_r;
            end else if (handshake_s) begin
                res_valid_r <= 1'b0;
            end
            if (handshake_s) begin
                done_cnt_r <= done_cnt_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_seq
// Self-checking bench for alu_cmd_seq with a one-stage behavioural ALU.
// Expected results are queued when a command is accepted and compared when
// the result handshake happens. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_seq;
    localparam int W       = 32;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic [2:0]   sel;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] alu_a, alu_b, alu_r;
    logic [2:0]   alu_sel;
    logic         alu_z;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb_q[$];

    alu_cmd_seq_if #(.W(W)) bus ();

    alu_cmd_seq #(.W(W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .o_ul_alu_a    (alu_a),
        .o_ul_alu_b    (alu_b),
        .o_u3_alu_sel  (alu_sel),
        .i_ul_alu_r    (alu_r),
        .i_b_alu_zflag (alu_z)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] sel);
        case (sel)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return ~a;
            3'b101:  return a << b[4:0];
            3'b110:  return a >> b[4:0];
            default: return a ^ b;
        endcase
    endfunction

    // Behavioural ALU: one register stage.
    always @(posedge clk) begin
        alu_r <= alu_fn(alu_a, alu_b, alu_sel);
        alu_z <= (alu_fn(alu_a, alu_b, alu_sel) == {W{1'b0}});
    end

    // Drive a command for the coming edge; queue its expected result if accepted.
    task automatic queue_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] sel, output bit accepted);
        exp_t e;
        bus.i_b_cmd_valid = 1'b1;
        bus.i_ul_a        = a;
        bus.i_ul_b        = b;
        bus.i_u3_sel      = sel;
        accepted          = bus.o_b_cmd_ready;
        if (accepted) begin
            e.r   = alu_fn(a, b, sel);
            e.z   = (e.r == {W{1'b0}});
            e.sel = sel;
            sb_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_b_cmd_valid = 1'b0;
        bus.i_ul_a = '0; bus.i_ul_b = '0; bus.i_u3_sel = 3'b000;
        bus.i_b_res_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.o_b_cmd_ready, bus.o_b_res_valid, bus.o_ul_r, bus.o_bi_zflag,
                 bus.o_u3_res_sel, bus.o_u8_done_cnt, alu_a, alu_b, alu_sel} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got rdy=%b vld=%b r=%h z=%b sel=%b cnt=%0d a=%h b=%h asel=%b, expected all 0",
                         bus.o_b_cmd_ready, bus.o_b_res_valid, bus.o_ul_r, bus.o_bi_zflag,
                         bus.o_u3_res_sel, bus.o_u8_done_cnt, alu_a, alu_b, alu_sel);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_b_cmd_ready !== 1'b1 || bus.o_b_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0",
                     bus.o_b_cmd_ready, bus.o_b_res_valid);
        end
    endtask

    task automatic test_single();
        bit   acc;
        exp_t e;
        bus.i_b_res_ready = 1'b1;
        queue_cmd(32'h0C041820, 32'h24208100, 3'b000, acc);
        @(negedge clk);                      // after edge 1: pushed, not yet issued
        bus.i_b_cmd_valid = 1'b0;
        checks++;
        if (alu_a !== 32'h0 || bus.o_b_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass: got alu_a=%h vld=%b, expected alu_a=0 vld=0", alu_a, bus.o_b_res_valid);
        end
        @(negedge clk);                      // after edge 2: issued
        checks++;
        if (alu_a !== 32'h0C041820 || alu_b !== 32'h24208100 || alu_sel !== 3'b000) begin
            errors++;
            $display("FAIL single_issue: got a=%h b=%h sel=%b, expected a=0c041820 b=24208100 sel=000",
                     alu_a, alu_b, alu_sel);
        end
        @(negedge clk);                      // after edge 3
        checks++;
        if (bus.o_b_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got vld=%b, expected 0", bus.o_b_res_valid);
        end
        @(negedge clk);                      // after edge 4: result captured
        checks++;
        if (bus.o_b_res_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL single_valid: got vld=%b queued=%0d, expected vld=1 queued=1",
                     bus.o_b_res_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (bus.o_ul_r !== e.r || bus.o_bi_zflag !== e.z || bus.o_u3_res_sel !== e.sel) begin
                errors++;
                $display("FAIL single_result: got r=%h z=%b sel=%b, expected r=%h z=%b sel=%b",
                         bus.o_ul_r, bus.o_bi_zflag, bus.o_u3_res_sel, e.r, e.z, e.sel);
            end
        end
        @(negedge clk);                      // after edge 5: handshake done
        checks++;
        if (bus.o_b_res_valid !== 1'b0 || bus.o_u8_done_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_done: got vld=%b cnt=%0d, expected vld=0 cnt=1",
                     bus.o_b_res_valid, bus.o_u8_done_cnt);
        end
    endtask

    task automatic test_fill();
        bit       acc;
        exp_t     e;
        int       last_i;
        logic [2:0] sels [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        bus.i_b_res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            queue_cmd($urandom, $urandom, sels[k], acc);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin    // extra command must be refused
            checks++;
            if (bus.o_b_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill_full: got rdy=%b, expected 0", bus.o_b_cmd_ready);
            end
            queue_cmd($urandom, $urandom, 3'b100, acc);
            @(negedge clk);
        end
        bus.i_b_cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.o_b_res_valid !== 1'b1 || bus.o_ul_r !== sb_q[0].r || bus.o_u3_res_sel !== sb_q[0].sel) begin
                errors++;
                $display("FAIL fill_hold: got vld=%b r=%h sel=%b, expected vld=1 r=%h sel=%b",
                         bus.o_b_res_valid, bus.o_ul_r, bus.o_u3_res_sel, sb_q[0].r, sb_q[0].sel);
            end
            @(negedge clk);
        end
        bus.i_b_res_ready = 1'b1;
        last_i = -1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            if (bus.o_b_res_valid === 1'b1) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.o_ul_r !== e.r || bus.o_bi_zflag !== e.z || bus.o_u3_res_sel !== e.sel) begin
                    errors++;
                    $display("FAIL fill_result: got r=%h z=%b sel=%b, expected r=%h z=%b sel=%b",
                             bus.o_ul_r, bus.o_bi_zflag, bus.o_u3_res_sel, e.r, e.z, e.sel);
                end
                if (last_i >= 0) begin
                    checks++;
                    if (i - last_i != ALU_LAT + 2) begin
                        errors++;
                        $display("FAIL fill_rate: got gap %0d, expected %0d", i - last_i, ALU_LAT + 2);
                    end
                end
                last_i = i;
            end
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL fill_drain: got %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_zero();
        bit   acc;
        exp_t e;
        int   n = 0;
        bus.i_b_res_ready = 1'b1;
        queue_cmd(32'h0, 32'h0, 3'b111, acc);
        @(negedge clk);
        queue_cmd(32'h5, 32'h3, 3'b000, acc);
        @(negedge clk);
        bus.i_b_cmd_valid = 1'b0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (bus.o_b_res_valid === 1'b1 && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.o_ul_r !== e.r || bus.o_bi_zflag !== e.z || bus.o_u3_res_sel !== e.sel) begin
                    errors++;
                    $display("FAIL zero_result: got r=%h z=%b sel=%b, expected r=%h z=%b sel=%b",
                             bus.o_ul_r, bus.o_bi_zflag, bus.o_u3_res_sel, e.r, e.z, e.sel);
                end
                checks++;
                if (bus.o_bi_zflag !== (n == 0)) begin
                    errors++;
                    $display("FAIL zero_flag: got z=%b on result %0d, expected %b", bus.o_bi_zflag, n, (n == 0));
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL zero_timeout: got %0d results, expected 2", n);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        bus.i_b_res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            queue_cmd($urandom, $urandom, 3'($urandom_range(0, 7)), acc);
            @(negedge clk);
        end
        bus.i_b_cmd_valid = 1'b0;
        checks++;
        if (bus.o_b_res_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold: got vld=%b, expected 1", bus.o_b_res_valid);
        end
        bus.i_b_res_ready = 1'b1;            // one handshake -> WAIT with 3 queued
        void'(sb_q.pop_front());
        @(negedge clk);
        bus.i_b_res_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        sb_q.delete();
        checks++;
        if (bus.o_b_res_valid !== 1'b0 || bus.o_u8_done_cnt !== 8'd0 || bus.o_b_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b cnt=%0d rdy=%b, expected 0 0 0",
                     bus.o_b_res_valid, bus.o_u8_done_cnt, bus.o_b_cmd_ready);
        end
        rst_n = 1'b1;
        bus.i_b_res_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_b_res_valid !== 1'b0 || bus.o_u8_done_cnt !== 8'd0 || bus.o_b_cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_after: got vld=%b cnt=%0d rdy=%b, expected 0 0 1",
                         bus.o_b_res_valid, bus.o_u8_done_cnt, bus.o_b_cmd_ready);
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        bit         acc;
        exp_t       e;
        int         sent = 0;
        int         handled = 0;
        logic [7:0] exp_cnt = 8'd0;
        for (int i = 0; i < 4000 && handled < 256; i++) begin
            checks++;
            if (bus.o_u8_done_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL wrap_count: got %0d, expected %0d", bus.o_u8_done_cnt, exp_cnt);
            end
            bus.i_b_res_ready = ($urandom_range(0, 3) != 0);
            if (bus.o_b_res_valid === 1'b1 && bus.i_b_res_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_unexpected: got r=%h, expected no result", bus.o_ul_r);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (bus.o_ul_r !== e.r || bus.o_bi_zflag !== e.z || bus.o_u3_res_sel !== e.sel) begin
                        errors++;
                        $display("FAIL wrap_result: got r=%h z=%b sel=%b, expected r=%h z=%b sel=%b",
                                 bus.o_ul_r, bus.o_bi_zflag, bus.o_u3_res_sel, e.r, e.z, e.sel);
                    end
                end
                exp_cnt = exp_cnt + 8'd1;
                handled++;
            end
            if (sent < 256 && $urandom_range(0, 4) != 0) begin
                queue_cmd($urandom, $urandom, 3'($urandom_range(0, 7)), acc);
                if (acc) sent++;
            end else begin
                bus.i_b_cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.i_b_cmd_valid = 1'b0;
        bus.i_b_res_ready = 1'b0;
        checks++;
        if (handled != 256 || bus.o_u8_done_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_final: got %0d handshakes cnt=%0d, expected 256 cnt=0",
                     handled, bus.o_u8_done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_zero();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_seq.md
Name: alu_cmd_seq

Overview:
- Upstream issue stage for the ALU_BLOQ clocked ALU.
- Accepts operand/selector commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU operand and selector ports with held-stable values, waits the ALU's registered latency, then captures the result and zero flag.
- Presents the captured result downstream over a second valid/ready interface. Decouples command producers from ALU timing.

Parameters:
- W, 32, operand/result width.
- DEPTH, 4, command FIFO depth; power of two, ≥2.
- ALU_LAT, 1, ALU register stages between operand inputs and o_ul_r/o_bi_zflag; ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_b_cmd_valid  in  1  command present.
- o_b_cmd_ready  out  1  FIFO can accept a command.
- i_ul_a  in  W  operand A.
- i_ul_b  in  W  operand B.
- i_u3_sel  in  3  ALU operation select.
- o_ul_alu_a  out  W  to ALU i_ul_a.
- o_ul_alu_b  out  W  to ALU i_ul_b.
- o_u3_alu_sel  out  3  to ALU i_u3_sel.
- i_ul_alu_r  in  W  from ALU o_ul_r.
- i_b_alu_zflag  in  1  from ALU o_bi_zflag.
- o_b_res_valid  out  1  result held for downstream.
- i_b_res_ready  in  1  downstream accepts result.
- o_ul_r  out  W  captured result.
- o_bi_zflag  out  1  captured zero flag.
- o_u3_res_sel  out  3  selector that produced o_ul_r.
- o_u8_done_cnt  out  8  completed result handshakes; wraps 255→0.

Behaviour:
- Reset: sampled on the clk edge with rst_n=0. On that edge:
  - FIFO is emptied and state goes to IDLE.
  - All outputs are cleared to 0, including o_b_cmd_ready; o_b_cmd_ready is 1 from the first edge after rst_n returns high.
  - Asserting reset mid-operation discards queued commands, any in-flight ALU op and any held result. o_b_res_valid drops and no handshake is counted.
- FIFO:
  - o_b_cmd_ready = not full (registered count).
  - Push on an edge with i_b_cmd_valid & o_b_cmd_ready.
  - Push and pop on the same edge leave the count unchanged.
  - No push while full. No bypass: a command pushed into an empty FIFO is popped no earlier than the next edge.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO non-empty, pop head into the registers driving o_ul_alu_a/b and o_u3_alu_sel, load wait counter = ALU_LAT+1, go WAIT.
  - WAIT: decrement each edge. On the edge where the counter is 1, capture i_ul_alu_r into o_ul_r, i_b_alu_zflag into o_bi_zflag and the issued sel into o_u3_res_sel; set o_b_res_valid=1; go HOLD. Result is therefore captured on the (ALU_LAT+1)th edge after the pop edge.
  - HOLD: o_b_res_valid=1. o_ul_r, o_bi_zflag and o_u3_res_sel are stable until the handshake.
    - On i_b_res_ready: o_b_res_valid=0 next cycle and o_u8_done_cnt increments.
    - If the FIFO is non-empty on that same edge, pop and go WAIT (back-to-back); else go IDLE.
- ALU drive outputs hold their last issued values in IDLE/HOLD and change only on a pop edge.
- Throughput with ready held high: one result per ALU_LAT+2 cycles.
- i_b_res_ready while not HOLD is ignored.
- o_u8_done_cnt wraps 255→0 with no other effect.

Test Plan:
- Reset with ALU_LAT=1, rst_n=0 for 3 edges, then released → all outputs 0 during reset; o_b_cmd_ready=1 one edge after release; FIFO empty.
- Single op: push a=0x0C041820, b=0x24208100, sel=000 on edge 1, i_b_res_ready=1 → ALU ports carry these after edge 2; o_b_res_valid=1 after edge 4 with o_ul_r equal to the ALU's output for that op; o_u3_res_sel=000; o_u8_done_cnt=1 after edge 5.
- Fill: i_b_res_ready=0, push 5 commands back-to-back with sels 000, 001, 010, 011, 101 → o_b_cmd_ready=0 once 4 are queued plus the one issued; first result held stable indefinitely. Then raise ready → remaining results appear in order every 3 cycles.
- Zero flag: a=0, b=0, sel=111 → o_bi_zflag=1 and o_ul_r=0 captured; next op with a nonzero result → o_bi_zflag=0.
- Reset mid-operation: assert rst_n=0 during WAIT with 3 commands queued → no o_b_res_valid afterwards, o_u8_done_cnt=0, FIFO empty.
- Counter wrap: 256 completed handshakes → o_u8_done_cnt returns to 0.
